// File: rtl/rf_wb_sched.sv
`timescale 1ns/1ps
// rf_wb_sched
// Write-back scheduler and port controller for the single-write-port
// accumulator register file (entry 0 is the accumulator). Three requesters
// share the one write port and the shared read/write index:
//   - ALU result write-back      (alu_*)
//   - data-memory load write-back (ld_*)
//   - two-cycle Acc <-> Rn swap   (swp_*)
// Grant priority in IDLE is: starving ALU, then load, then swap, then ALU.
//
// Handshake: a transfer happens in a cycle where valid && ready are both
// high. ready is combinational from inputs and state and never waits for
// valid to go low. The payload only has to be stable in the transfer cycle,
// and the register file write commits at the closing posedge.
//
// Ports
//   CLK, Reset_n                  clock, synchronous active-low reset
//   alu_valid/alu_ready, alu_dest_acc, alu_idx, alu_data   ALU write-back
//   ld_valid/ld_ready, ld_idx, ld_data                      load write-back
//   swp_valid/swp_ready, swp_idx                            swap request
//   rd_idx                        datapath operand read index
//   rd_ok                         rf_Reg_out currently reflects rd_idx
//   rf_Acc_out, rf_Reg_out        register file read data
//   rf_RegWrite, rf_AccWrite      register file write enables
//   rf_reg_index, rf_writeValue   register file index and write data
//   swap_busy                     high during the second swap cycle
//   dbg_state                     FSM state (0 = IDLE, 1 = SWAP2)
module rf_wb_sched #(
  parameter int W      = 8,
  parameter int D      = 4,
  parameter int STARVE = 4
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic         alu_valid,
  output logic         alu_ready,
  input  logic         alu_dest_acc,
  input  logic [D-1:0] alu_idx,
  input  logic [W-1:0] alu_data,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [D-1:0] ld_idx,
  input  logic [W-1:0] ld_data,
  input  logic         swp_valid,
  output logic         swp_ready,
  input  logic [D-1:0] swp_idx,
  input  logic [D-1:0] rd_idx,
  output logic         rd_ok,
  input  logic [W-1:0] rf_Acc_out,
  input  logic [W-1:0] rf_Reg_out,
  output logic         rf_RegWrite,
  output logic         rf_AccWrite,
  output logic [D-1:0] rf_reg_index,
  output logic [W-1:0] rf_writeValue,
  output logic         swap_busy,
  output logic         dbg_state
);

  typedef enum logic {IDLE = 1'b0, SWAP2 = 1'b1} state_t;

  localparam logic [3:0] STARVE_C = 4'(STARVE);

  state_t       state_q, state_d;
  logic [3:0]   wait_cnt_q, wait_cnt_d;
  logic [W-1:0] acc_tmp_q;
  logic [D-1:0] swp_idx_q;

  logic in_idle, in_swap2, starve_win;
  logic alu_to_acc, ld_to_acc, swap_start;

  // ---------------------------------------------------------------- state
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      acc_tmp_q  <= '0;
      swp_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (swap_start) begin
        acc_tmp_q <= rf_Acc_out;
        swp_idx_q <= swp_idx;
      end
    end
  end

  // ---------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (swap_start) state_d = SWAP2;
      SWAP2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU wait counter saturates at STARVE; it keeps counting while a swap
  // holds the port, so a swap can delay a starving ALU by one extra cycle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!alu_valid || alu_ready)
      wait_cnt_d = '0;
    else if (wait_cnt_q != STARVE_C)
      wait_cnt_d = wait_cnt_q + 4'd1;
  end

  // -------------------------------------------------------------- grants
  // Reset forces every grant low so nothing is written while held in reset;
  // this also drops the pending second swap write.
  assign in_idle    = Reset_n && (state_q == IDLE);
  assign in_swap2   = Reset_n && (state_q == SWAP2);
  assign starve_win = alu_valid && (wait_cnt_q == STARVE_C);

  assign alu_ready = in_idle && alu_valid && (starve_win || (!ld_valid && !swp_valid));
  assign ld_ready  = in_idle && ld_valid && !starve_win;
  assign swp_ready = in_idle && swp_valid && !ld_valid && !starve_win;

  assign alu_to_acc = alu_dest_acc || (alu_idx == '0);
  assign ld_to_acc  = (ld_idx == '0);
  // A swap with index 0 is accepted but is a no-op.
  assign swap_start = swp_ready && (swp_idx != '0);

  // --------------------------------------------------------------- index
  // Kept apart from the write-data process: the first swap cycle reads Rn
  // through rf_Reg_out, which depends on this index.
  always_comb begin
    rf_reg_index = rd_idx;
    if (alu_ready && !alu_to_acc) rf_reg_index = alu_idx;
    if (ld_ready && !ld_to_acc)   rf_reg_index = ld_idx;
    if (swap_start)               rf_reg_index = swp_idx;
    if (in_swap2)                 rf_reg_index = swp_idx_q;
  end

  // ------------------------------------------------ write enables / data
  always_comb begin
    rf_RegWrite   = 1'b0;
    rf_AccWrite   = 1'b0;
    rf_writeValue = '0;
    if (alu_ready) begin
      rf_AccWrite   = alu_to_acc;
      rf_RegWrite   = !alu_to_acc;
      rf_writeValue = alu_data;
    end
    if (ld_ready) begin
      rf_AccWrite   = ld_to_acc;
      rf_RegWrite   = !ld_to_acc;
      rf_writeValue = ld_data;
    end
    if (swap_start) begin
      // Cycle 1: Acc <= Rn, old Acc saved in acc_tmp.
      rf_AccWrite   = 1'b1;
      rf_writeValue = rf_Reg_out;
    end
    if (in_swap2) begin
      // Cycle 2: Rn <= old Acc.
      rf_RegWrite   = 1'b1;
      rf_writeValue = acc_tmp_q;
    end
  end

  assign rd_ok     = (rf_reg_index == rd_idx);
  assign swap_busy = in_swap2;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
`timescale 1ns/1ps
module tb_rf_wb_sched;

  logic       CLK = 1'b0;
  logic       Reset_n;
  logic       alu_valid, alu_ready, alu_dest_acc;
  logic [3:0] alu_idx;
  logic [7:0] alu_data;
  logic       ld_valid, ld_ready;
  logic [3:0] ld_idx;
  logic [7:0] ld_data;
  logic       swp_valid, swp_ready;
  logic [3:0] swp_idx, rd_idx;
  logic       rd_ok;
  logic [7:0] rf_Acc_out, rf_Reg_out;
  logic       rf_RegWrite, rf_AccWrite;
  logic [3:0] rf_reg_index;
  logic [7:0] rf_writeValue;
  logic       swap_busy, dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // clock / reset block
  always #5 CLK = ~CLK;

  rf_wb_sched #(.W(8), .D(4), .STARVE(4)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest_acc(alu_dest_acc),
    .alu_idx(alu_idx), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_idx(ld_idx), .ld_data(ld_data),
    .swp_valid(swp_valid), .swp_ready(swp_ready), .swp_idx(swp_idx),
    .rd_idx(rd_idx), .rd_ok(rd_ok),
    .rf_Acc_out(rf_Acc_out), .rf_Reg_out(rf_Reg_out),
    .rf_RegWrite(rf_RegWrite), .rf_AccWrite(rf_AccWrite),
    .rf_reg_index(rf_reg_index), .rf_writeValue(rf_writeValue),
    .swap_busy(swap_busy), .dbg_state(dbg_state)
  );

  // Register file model (not reset by Reset_n), with a bench preload port.
  logic [7:0] rf_mem [16];
  logic       pl_en = 1'b0;
  logic [3:0] pl_idx = '0;
  logic [7:0] pl_val = '0;

  assign rf_Acc_out = rf_mem[0];
  assign rf_Reg_out = rf_mem[rf_reg_index];

  always @(posedge CLK) begin
    if (pl_en) rf_mem[pl_idx] <= pl_val;
    if (rf_AccWrite) rf_mem[0] <= rf_writeValue;
    if (rf_RegWrite) rf_mem[rf_reg_index] <= rf_writeValue;
  end

  // ---------------------------------------------------------- checkers
  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------- drivers
  task automatic idle_in();
    alu_valid = 1'b0; alu_dest_acc = 1'b0; alu_idx = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_idx = '0; ld_data = '0;
    swp_valid = 1'b0; swp_idx = '0;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [7:0] val);
    @(negedge CLK);
    idle_in();
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  // Checks the full write-port picture of the current cycle.
  task automatic chk_port(input string nm, input logic ar, input logic lr, input logic sr,
                          input logic rw, input logic aw, input logic [3:0] idx,
                          input logic [7:0] wv);
    chk_b({nm, ".alu_ready"}, alu_ready, ar);
    chk_b({nm, ".ld_ready"}, ld_ready, lr);
    chk_b({nm, ".swp_ready"}, swp_ready, sr);
    chk_b({nm, ".RegWrite"}, rf_RegWrite, rw);
    chk_b({nm, ".AccWrite"}, rf_AccWrite, aw);
    chk_v({nm, ".reg_index"}, {4'h0, rf_reg_index}, {4'h0, idx});
    chk_v({nm, ".writeValue"}, rf_writeValue, wv);
  endtask

  // ---------------------------------------------------------- vectors
  typedef struct {
    logic       av, aacc;
    logic [3:0] aidx;
    logic [7:0] adat;
    logic       lv;
    logic [3:0] lidx;
    logic [7:0] ldat;
    logic       sv;
    logic [3:0] sidx;
    logic [3:0] rd;
    logic       e_ar, e_lr, e_sr, e_rw, e_aw;
    logic [3:0] e_idx;
    logic [7:0] e_wv;
    logic       e_ok;
  } vec_t;

  vec_t vecs [10];

  initial begin
    //          av aacc aidx adat   lv lidx ldat   sv sidx rd   ar lr sr rw aw idx  wv     ok
    vecs[0] = '{1, 0, 4'd4, 8'h11,  0, 4'd0, 8'h00, 0, 4'd0, 4'd2,  1, 0, 0, 1, 0, 4'd4, 8'h11, 0};
    vecs[1] = '{1, 1, 4'd6, 8'h22,  0, 4'd0, 8'h00, 0, 4'd0, 4'd3,  1, 0, 0, 0, 1, 4'd3, 8'h22, 1};
    vecs[2] = '{1, 0, 4'd0, 8'h5A,  0, 4'd0, 8'h00, 0, 4'd0, 4'd9,  1, 0, 0, 0, 1, 4'd9, 8'h5A, 1};
    vecs[3] = '{0, 0, 4'd0, 8'h00,  1, 4'd3, 8'hA5, 0, 4'd0, 4'd1,  0, 1, 0, 1, 0, 4'd3, 8'hA5, 0};
    vecs[4] = '{0, 0, 4'd0, 8'h00,  1, 4'd0, 8'h77, 0, 4'd0, 4'd5,  0, 1, 0, 0, 1, 4'd5, 8'h77, 1};
    vecs[5] = '{1, 0, 4'd4, 8'h11,  1, 4'd3, 8'hA5, 0, 4'd0, 4'd6,  0, 1, 0, 1, 0, 4'd3, 8'hA5, 0};
    vecs[6] = '{0, 0, 4'd0, 8'h00,  1, 4'd8, 8'h3C, 1, 4'd7, 4'd8,  0, 1, 0, 1, 0, 4'd8, 8'h3C, 1};
    vecs[7] = '{1, 0, 4'd4, 8'h11,  0, 4'd0, 8'h00, 1, 4'd0, 4'd6,  0, 0, 1, 0, 0, 4'd6, 8'h00, 1};
    vecs[8] = '{0, 0, 4'd0, 8'h00,  0, 4'd0, 8'h00, 0, 4'd0, 4'd12, 0, 0, 0, 0, 0, 4'd12, 8'h00, 1};
    vecs[9] = '{1, 1, 4'd0, 8'hC3,  0, 4'd0, 8'h00, 0, 4'd0, 4'd0,  1, 0, 0, 0, 1, 4'd0, 8'hC3, 1};

    // ---- reset with all requesters valid
    Reset_n = 1'b0;
    alu_valid = 1'b1; alu_dest_acc = 1'b0; alu_idx = 4'd4; alu_data = 8'h11;
    ld_valid  = 1'b1; ld_idx = 4'd1; ld_data = 8'h4E;
    swp_valid = 1'b1; swp_idx = 4'd7;
    rd_idx = 4'd5;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK); #2;
      chk_port("reset", 0, 0, 0, 0, 0, 4'd5, 8'h00);
      chk_b("reset.swap_busy", swap_busy, 1'b0);
    end
    @(negedge CLK);
    Reset_n = 1'b1;
    #2;
    chk_port("post_reset", 0, 1, 0, 1, 0, 4'd1, 8'h4E);
    chk_b("post_reset.state", dbg_state, 1'b0);
    @(negedge CLK);
    idle_in();
    #2;
    chk_v("post_reset.R1", rf_mem[1], 8'h4E);

    // ---- table: single-cycle grants from IDLE, idle spacer between
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      alu_valid = vecs[i].av; alu_dest_acc = vecs[i].aacc;
      alu_idx = vecs[i].aidx; alu_data = vecs[i].adat;
      ld_valid = vecs[i].lv; ld_idx = vecs[i].lidx; ld_data = vecs[i].ldat;
      swp_valid = vecs[i].sv; swp_idx = vecs[i].sidx;
      rd_idx = vecs[i].rd;
      #2;
      chk_port($sformatf("vec%0d", i), vecs[i].e_ar, vecs[i].e_lr, vecs[i].e_sr,
               vecs[i].e_rw, vecs[i].e_aw, vecs[i].e_idx, vecs[i].e_wv);
      chk_b($sformatf("vec%0d.rd_ok", i), rd_ok, vecs[i].e_ok);
      chk_b($sformatf("vec%0d.swap_busy", i), swap_busy, 1'b0);
      @(negedge CLK);
      idle_in();
    end

    // ---- priority: load first, ALU next cycle
    @(negedge CLK);
    ld_valid = 1'b1; ld_idx = 4'd3; ld_data = 8'hA5;
    alu_valid = 1'b1; alu_dest_acc = 1'b0; alu_idx = 4'd4; alu_data = 8'h11;
    rd_idx = 4'd0;
    #2;
    chk_port("prio.c0", 0, 1, 0, 1, 0, 4'd3, 8'hA5);
    @(negedge CLK);
    ld_valid = 1'b0;
    #2;
    chk_port("prio.c1", 1, 0, 0, 1, 0, 4'd4, 8'h11);
    @(negedge CLK);
    idle_in();
    #2;
    chk_v("prio.R3", rf_mem[3], 8'hA5);
    chk_v("prio.R4", rf_mem[4], 8'h11);

    // ---- swap Acc <-> R7
    preload(4'd0, 8'h12);
    preload(4'd7, 8'h34);
    @(negedge CLK);
    swp_valid = 1'b1; swp_idx = 4'd7; rd_idx = 4'd2;
    #2;
    chk_port("swap.c0", 0, 0, 1, 0, 1, 4'd7, 8'h34);
    chk_b("swap.c0.rd_ok", rd_ok, 1'b0);
    chk_b("swap.c0.busy", swap_busy, 1'b0);
    @(negedge CLK);
    swp_valid = 1'b0;
    alu_valid = 1'b1; alu_dest_acc = 1'b0; alu_idx = 4'd9; alu_data = 8'h99;
    #2;
    chk_port("swap.c1", 0, 0, 0, 1, 0, 4'd7, 8'h12);
    chk_b("swap.c1.busy", swap_busy, 1'b1);
    chk_b("swap.c1.state", dbg_state, 1'b1);
    @(negedge CLK);
    #2;
    chk_port("swap.c2", 1, 0, 0, 1, 0, 4'd9, 8'h99);
    chk_b("swap.c2.busy", swap_busy, 1'b0);
    @(negedge CLK);
    idle_in();
    #2;
    chk_v("swap.Acc", rf_mem[0], 8'h34);
    chk_v("swap.R7", rf_mem[7], 8'h12);
    chk_v("swap.R9", rf_mem[9], 8'h99);

    // ---- index 0: ALU non-acc destination 0 goes to the accumulator
    @(negedge CLK);
    alu_valid = 1'b1; alu_dest_acc = 1'b0; alu_idx = 4'd0; alu_data = 8'h5A; rd_idx = 4'd3;
    #2;
    chk_port("idx0.alu", 1, 0, 0, 0, 1, 4'd3, 8'h5A);
    @(negedge CLK);
    idle_in();
    #2;
    chk_v("idx0.Acc", rf_mem[0], 8'h5A);

    // ---- swap with index 0: one cycle, no writes
    @(negedge CLK);
    swp_valid = 1'b1; swp_idx = 4'd0;
    #2;
    chk_port("swap0.c0", 0, 0, 1, 0, 0, 4'd3, 8'h00);
    @(negedge CLK);
    idle_in();
    #2;
    chk_b("swap0.c1.busy", swap_busy, 1'b0);
    chk_b("swap0.c1.state", dbg_state, 1'b0);
    chk_v("swap0.Acc", rf_mem[0], 8'h5A);

    // ---- starvation: load held, ALU wins in the 5th cycle
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      ld_valid = 1'b1; ld_idx = 4'd1; ld_data = 8'h10 + 8'(c);
      alu_valid = (c < 5); alu_dest_acc = 1'b0; alu_idx = 4'd2; alu_data = 8'hEE;
      #2;
      chk_b($sformatf("starve.c%0d.alu_ready", c), alu_ready, c == 4);
      chk_b($sformatf("starve.c%0d.ld_ready", c), ld_ready, c != 4);
    end
    @(negedge CLK);
    idle_in();
    #2;
    chk_v("starve.R2", rf_mem[2], 8'hEE);
    chk_v("starve.R1", rf_mem[1], 8'h15);

    // ---- reset during SWAP2 drops the second write
    preload(4'd0, 8'h01);
    preload(4'd2, 8'h02);
    @(negedge CLK);
    swp_valid = 1'b1; swp_idx = 4'd2; rd_idx = 4'd6;
    #2;
    chk_port("rst_swap.c0", 0, 0, 1, 0, 1, 4'd2, 8'h02);
    @(negedge CLK);
    swp_valid = 1'b0;
    Reset_n = 1'b0;
    #2;
    chk_port("rst_swap.c1", 0, 0, 0, 0, 0, 4'd6, 8'h00);
    chk_b("rst_swap.c1.busy", swap_busy, 1'b0);
    @(negedge CLK);
    Reset_n = 1'b1;
    #2;
    chk_b("rst_swap.state", dbg_state, 1'b0);
    chk_port("rst_swap.c2", 0, 0, 0, 0, 0, 4'd6, 8'h00);
    chk_v("rst_swap.Acc", rf_mem[0], 8'h02);
    chk_v("rst_swap.R2", rf_mem[2], 8'h02);

    // ---- report
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
